// File: rtl/matrixmult_arb_pkg.sv
// rtl/matrixmult_arb_pkg.sv - shared widths, tag type and helpers for the multiplier arbiter
package matrixmult_arb_pkg;

    localparam int DEF_DIN_W  = 16;
    localparam int DEF_DOUT_W = 32;
    localparam int CNT_W      = 16;

    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_W   = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/matrixmult_mul_core.sv
// rtl/matrixmult_mul_core.sv - signed multiplier with MUL_LAT clock-enabled stages
module matrixmult_mul_core
    import matrixmult_arb_pkg::*;
#(
    parameter int DIN_W   = DEF_DIN_W,
    parameter int DOUT_W  = DEF_DOUT_W,
    parameter int MUL_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic signed [DIN_W-1:0]  a,
    input  logic signed [DIN_W-1:0]  b,
    output logic signed [DOUT_W-1:0] p
);

    logic signed [DOUT_W-1:0] a_ext;
    logic signed [DOUT_W-1:0] b_ext;
    logic signed [DOUT_W-1:0] prod;
    logic signed [DOUT_W-1:0] stage [MUL_LAT];

    // Sign-extend to the full product width so the low DOUT_W bits are exact.
    assign a_ext = {{(DOUT_W-DIN_W){a[DIN_W-1]}}, a};
    assign b_ext = {{(DOUT_W-DIN_W){b[DIN_W-1]}}, b};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                stage[i] <= '0;
            end
        end else if (ce) begin
            stage[0] <= prod;
            for (int i = 1; i < MUL_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign p = stage[MUL_LAT-1];

endmodule

// File: rtl/matrixmult_mul_arbiter.sv
// rtl/matrixmult_mul_arbiter.sv - round-robin arbiter sharing one pipelined signed multiplier
// Optional per-requester grant and stall counters: define MATRIXMULT_ARB_STATS_EN.
module matrixmult_mul_arbiter
    import matrixmult_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DIN_W   = DEF_DIN_W,
    parameter int DOUT_W  = DEF_DOUT_W,
    parameter int MUL_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*DIN_W-1:0]      req_a,
    input  logic [NREQ*DIN_W-1:0]      req_b,
    output logic                       rsp_valid,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [DOUT_W-1:0]          rsp_data,
    input  logic                       rsp_ready
`ifdef MATRIXMULT_ARB_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0]      stat_grants,
    output logic [CNT_W-1:0]           stat_stalls
`endif
);

    localparam int ID_W = $clog2(NREQ);

    logic                    ce;
    logic                    found;
    logic                    fire;
    logic [ID_W-1:0]         ptr;
    logic [ID_W-1:0]         ptr_next;
    logic [ID_W-1:0]         grant_idx;
    logic [ID_W:0]           offset;
    logic [ID_W:0]           grant_sum;
    logic [2*NREQ-1:0]       req_dbl;
    logic [NREQ-1:0]         req_rot;
    logic signed [DIN_W-1:0] mul_a;
    logic signed [DIN_W-1:0] mul_b;
    tag_t                    tag_in;
    tag_t                    tag_last;
    tag_t                    tag_pipe [MUL_LAT];
    logic                    unused_tag_hi;

    assign ce = ~(rsp_valid & ~rsp_ready);

    // Rotate the request vector so bit 0 is the requester at ptr.
    assign req_dbl = {req_valid, req_valid};
    assign req_rot = req_dbl[ptr +: NREQ];

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found  = 1'b1;
                offset = (ID_W+1)'(k);
            end
        end
    end

    assign grant_sum = {1'b0, ptr} + offset;
    assign grant_idx = (grant_sum >= (ID_W+1)'(NREQ)) ?
                       ID_W'(grant_sum - (ID_W+1)'(NREQ)) : grant_sum[ID_W-1:0];
    assign ptr_next  = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    assign fire      = found & ce;

    always_comb begin
        req_ready = '0;
        if (fire) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Bubbles feed zero operands so an idle output reads as zero.
    assign mul_a = fire ? req_a[int'(grant_idx)*DIN_W +: DIN_W] : '0;
    assign mul_b = fire ? req_b[int'(grant_idx)*DIN_W +: DIN_W] : '0;

    always_comb begin
        tag_in = '0;
        if (fire) begin
            tag_in.valid = 1'b1;
            tag_in.id    = TAG_ID_W'(grant_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
            ptr <= '0;
        end else if (ce) begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            if (fire) begin
                ptr <= ptr_next;
            end
        end
    end

    assign tag_last      = tag_pipe[MUL_LAT-1];
    assign rsp_valid     = tag_last.valid;
    assign rsp_id        = tag_last.id[ID_W-1:0];
    assign unused_tag_hi = ^tag_last.id;

    matrixmult_mul_core #(
        .DIN_W   (DIN_W),
        .DOUT_W  (DOUT_W),
        .MUL_LAT (MUL_LAT)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .a     (mul_a),
        .b     (mul_b),
        .p     (rsp_data)
    );

`ifdef MATRIXMULT_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt [NREQ];
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt[i] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            if (!ce) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (fire) begin
                grant_cnt[grant_idx] <= sat_inc(grant_cnt[grant_idx]);
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_stat
        assign stat_grants[i*CNT_W +: CNT_W] = grant_cnt[i];
    end
    assign stat_stalls = stall_cnt;
`else
    // Counters are not built in this configuration.
`endif

endmodule
